// File: rtl/rect_fill_drawer.sv
// Rectangle / full-screen fill pixel generator feeding vga_adapter.
// Latches a clipped region on start and streams one pixel per unstalled cycle in raster order.
module rect_fill_drawer #(
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       start,
   input  logic       clear,
   input  logic [7:0] x0,
   input  logic [6:0] y0,
   input  logic [7:0] width,
   input  logic [6:0] height,
   input  logic [2:0] colour_in,
   input  logic       stall,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   localparam logic [8:0] ScrW = 9'(SCREEN_W);
   localparam logic [8:0] ScrH = 9'(SCREEN_H);

   typedef enum logic [1:0] {StIdle, StDraw, StFinish} state_e;

   state_e     state_q, state_d;
   logic [7:0] x_q, x_d;
   logic [6:0] y_q, y_d;
   logic [2:0] colour_q, colour_d;
   logic       plot_q, plot_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   // Latched region and the pending (next-to-present) pixel.
   logic [7:0] xs_q, xs_d;
   logic [7:0] xe_q, xe_d;
   logic [6:0] ye_q, ye_d;
   logic [7:0] cx_q, cx_d;
   logic [6:0] cy_q, cy_d;
   logic       last_q, last_d;

   logic [7:0] org_x, end_x;
   logic [6:0] org_y, end_y;
   logic [8:0] w_avail, h_avail, w_eff, h_eff;
   logic       area_zero;

   // Clip the requested region against the screen using 9-bit arithmetic.
   always_comb begin
      org_x   = x0;
      org_y   = y0;
      w_avail = '0;
      h_avail = '0;
      w_eff   = '0;
      h_eff   = '0;
      if (clear) begin
         org_x = '0;
         org_y = '0;
         w_eff = ScrW;
         h_eff = ScrH;
      end else if (({1'b0, x0} < ScrW) && ({2'b00, y0} < ScrH)) begin
         w_avail = ScrW - {1'b0, x0};
         h_avail = ScrH - {2'b00, y0};
         w_eff   = ({1'b0, width} < w_avail) ? {1'b0, width} : w_avail;
         h_eff   = ({2'b00, height} < h_avail) ? {2'b00, height} : h_avail;
      end
      area_zero = (w_eff == '0) || (h_eff == '0);
      end_x     = 8'({1'b0, org_x} + w_eff - 9'd1);
      end_y     = 7'({2'b00, org_y} + h_eff - 9'd1);
   end

   logic [7:0] cur_x, cur_xs, cur_xe, nxt_x;
   logic [6:0] cur_y, cur_ye, nxt_y;
   logic       row_end, at_last, present;

   // In IDLE the first pixel comes straight from the request so it appears one cycle after start.
   always_comb begin
      if (state_q == StIdle) begin
         cur_x  = org_x;
         cur_y  = org_y;
         cur_xs = org_x;
         cur_xe = end_x;
         cur_ye = end_y;
      end else begin
         cur_x  = cx_q;
         cur_y  = cy_q;
         cur_xs = xs_q;
         cur_xe = xe_q;
         cur_ye = ye_q;
      end
      row_end = (cur_x == cur_xe);
      at_last = row_end && (cur_y == cur_ye);
      nxt_x   = row_end ? cur_xs : cur_x + 8'd1;
      nxt_y   = row_end ? cur_y + 7'd1 : cur_y;
      present = ((state_q == StIdle) && start && !area_zero) ||
                ((state_q == StDraw) && !last_q && !stall);
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start) state_d = area_zero ? StFinish : StDraw;
         StDraw:   if (last_q) state_d = StFinish;
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = 1'b0;
      busy_d   = (state_d == StDraw);
      done_d   = (state_d == StFinish);
      xs_d     = xs_q;
      xe_d     = xe_q;
      ye_d     = ye_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      last_d   = last_q;
      if ((state_q == StIdle) && start) begin
         colour_d = colour_in;
         xs_d     = org_x;
         xe_d     = end_x;
         ye_d     = end_y;
      end
      if (present) begin
         x_d    = cur_x;
         y_d    = cur_y;
         plot_d = 1'b1;
         cx_d   = nxt_x;
         cy_d   = nxt_y;
         last_d = at_last;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         xs_q     <= '0;
         xe_q     <= '0;
         ye_q     <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         last_q   <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         xs_q     <= xs_d;
         xe_q     <= xe_d;
         ye_q     <= ye_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         last_q   <= last_d;
      end
   end

   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;
   assign plot   = plot_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_rect_fill_drawer.sv
// Directed bench for rect_fill_drawer: expected pixels are queued from a clipping model
// when a request is driven and popped as the DUT plots them.
module tb_rect_fill_drawer;

   logic       Clock = 1'b0;
   logic       Resetn = 1'b0;
   logic       start = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] x0 = '0;
   logic [6:0] y0 = '0;
   logic [7:0] width = '0;
   logic [6:0] height = '0;
   logic [2:0] colour_in = '0;
   logic       stall = 1'b0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [17:0] exp_q[$];

   rect_fill_drawer #(.SCREEN_W(160), .SCREEN_H(120)) dut (
      .Clock(Clock), .Resetn(Resetn), .start(start), .clear(clear),
      .x0(x0), .y0(y0), .width(width), .height(height), .colour_in(colour_in),
      .stall(stall), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge Clock);
      #1;
   endtask

   // Drives one request and checks every cycle up to and past done.
   task automatic run_rect(input int ax0, input int ay0, input int aw, input int ah,
                           input logic [2:0] col, input logic clr,
                           input int stall_slot, input int restart_at);
      int ox, oy, we, he, npix, nstall;
      logic [17:0] e;
      if (clr) begin
         ox = 0; oy = 0; we = 160; he = 120;
      end else if (ax0 >= 160 || ay0 >= 120) begin
         ox = ax0; oy = ay0; we = 0; he = 0;
      end else begin
         ox = ax0; oy = ay0;
         we = (aw < 160 - ax0) ? aw : 160 - ax0;
         he = (ah < 120 - ay0) ? ah : 120 - ay0;
      end
      npix = we * he;
      for (int yy = 0; yy < he; yy++)
         for (int xx = 0; xx < we; xx++)
            exp_q.push_back({8'(ox + xx), 7'(oy + yy), col});
      nstall = (stall_slot > 0 && stall_slot < npix) ? 1 : 0;

      x0 = 8'(ax0); y0 = 7'(ay0); width = 8'(aw); height = 7'(ah);
      colour_in = col; clear = clr; start = 1'b1;
      next_cycle();
      start = 1'b0;
      colour_in = ~col;
      for (int c = 0; c <= npix + nstall; c++) begin
         check("busy", busy, (c < npix + nstall) ? 1 : 0);
         check("done", done, (c == npix + nstall) ? 1 : 0);
         check("plot", plot, ((c < npix + nstall) && !(nstall == 1 && c == stall_slot)) ? 1 : 0);
         if (plot) begin
            check("pixel_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("pixel", {x, y, colour}, e);
            end
         end
         stall = (nstall == 1 && c + 1 == stall_slot);
         if (c == restart_at) begin
            start = 1'b1; x0 = 8'd50; y0 = 7'd50; width = 8'd7; height = 7'd7;
         end
         next_cycle();
         start = 1'b0;
         stall = 1'b0;
      end
      check("queue_empty", exp_q.size(), 0);
      exp_q.delete();
      for (int c = 0; c < 3; c++) begin
         check("idle_plot", plot, 0);
         check("idle_done", done, 0);
         check("idle_busy", busy, 0);
         next_cycle();
      end
   endtask

   initial begin
      #3;
      check("rst_xy", {x, y}, 0);
      check("rst_colour", colour, 0);
      check("rst_flags", {plot, busy, done}, 0);
      next_cycle();
      Resetn = 1'b1;
      next_cycle();

      run_rect(10, 20, 3, 2, 3'b100, 1'b0, -1, -1);
      run_rect(158, 118, 5, 5, 3'b010, 1'b0, -1, -1);
      run_rect(0, 0, 0, 5, 3'b001, 1'b0, -1, -1);
      run_rect(200, 10, 4, 4, 3'b011, 1'b0, -1, -1);
      run_rect(0, 0, 2, 2, 3'b110, 1'b0, 1, 2);
      run_rect(1, 1, 1, 1, 3'b101, 1'b0, -1, -1);
      run_rect(30, 40, 1, 9, 3'b000, 1'b1, -1, -1);

      // Reset during the third pixel of a 4x4 draw.
      x0 = 8'd5; y0 = 7'd6; width = 8'd4; height = 7'd4; colour_in = 3'b111; clear = 1'b0;
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      next_cycle();
      next_cycle();
      check("pre_reset_pixel", {x, y, colour, plot}, {8'd7, 7'd6, 3'b111, 1'b1});
      #2;
      Resetn = 1'b0;
      #1;
      check("async_xy", {x, y}, 0);
      check("async_colour", colour, 0);
      check("async_flags", {plot, busy, done}, 0);
      for (int c = 0; c < 2; c++) begin
         next_cycle();
         check("reset_done", done, 0);
      end
      Resetn = 1'b1;
      for (int c = 0; c < 2; c++) begin
         next_cycle();
         check("post_reset_done", done, 0);
         check("post_reset_plot", plot, 0);
      end
      run_rect(5, 6, 4, 4, 3'b011, 1'b0, -1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rect_fill_drawer.md
Name: rect_fill_drawer

Overview:
- Pixel-stream generator sitting directly upstream of vga_adapter in the 160x120, 3-bit-colour display path.
- On a start pulse it latches a rectangle (origin, size, colour) or a full-screen clear request.
- It then emits one pixel per cycle on x/y/colour/plot in raster order until the region is filled, then pulses done.
- Used for drawing the battle box, the player heart and screen clears without CPU/switch involvement.

Parameters:
- SCREEN_W, 160, horizontal resolution; x range 0..SCREEN_W-1
- SCREEN_H, 120, vertical resolution; y range 0..SCREEN_H-1

Ports:
- Clock  input  1  system clock (CLOCK_50 domain)
- Resetn  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- clear  input  1  sampled with start; 1 = fill whole screen, ignoring x0/y0/width/height
- x0  input  8  rectangle left column
- y0  input  7  rectangle top row
- width  input  8  rectangle width in pixels (0..255)
- height  input  7  rectangle height in pixels (0..127)
- colour_in  input  3  fill colour {R,G,B}
- stall  input  1  1 = freeze pixel stream this cycle
- x  output  8  pixel column to vga_adapter
- y  output  7  pixel row to vga_adapter
- colour  output  3  pixel colour to vga_adapter
- plot  output  1  write strobe to vga_adapter
- busy  output  1  high while in DRAW
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, Resetn=0): state=IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0; latched registers cleared. Reset mid-draw aborts immediately with no done pulse.
- All outputs are registered.
- States: IDLE, DRAW, FINISH.
- IDLE:
  - start=1 latches colour_in and the clipped region:
    - clear=1: origin (0,0), w_eff=SCREEN_W, h_eff=SCREEN_H.
    - clear=0: if x0>=SCREEN_W or y0>=SCREEN_H, area is zero. Otherwise w_eff=min(width, SCREEN_W-x0) and h_eff=min(height, SCREEN_H-y0).
  - Nonzero area goes to DRAW; zero area goes to FINISH.
  - start=0 stays in IDLE.
- DRAW:
  - Each non-stalled cycle, registers x/y to the current pixel with plot=1.
  - The first pixel, (x0,y0), is on the outputs the cycle after start is accepted.
  - Raster order: x increments first; at x0+w_eff-1, x returns to x0 and y increments.
  - After (x0+w_eff-1, y0+h_eff-1) is presented, go to FINISH.
  - Total plot-high cycles = w_eff*h_eff exactly, each coordinate once.
- stall=1 in DRAW: plot=0 that cycle, counters hold, and the next non-stalled cycle presents the pending pixel. The stream therefore never skips or repeats a pixel.
- FINISH: plot=0, busy=0, done=1 for exactly one cycle, then IDLE. x/y hold their last values.
- busy=1 for exactly the cycles the FSM is in DRAW.
- start asserted while in DRAW or FINISH is ignored; it is not queued.
- Arithmetic: clipping uses 9-bit intermediates, so x0+width must not overflow. Output x never exceeds SCREEN_W-1 and y never exceeds SCREEN_H-1.
- colour is held constant for the whole operation; a colour_in change mid-draw has no effect.
- Latency:
  - start to first plot: 1 cycle.
  - start to done: w_eff*h_eff + stalled_cycles + 1 cycles.
  - Zero-area request: done is 1 cycle after start, and plot never asserts.

Test Plan:
- Reset then start with x0=10, y0=20, width=3, height=2, colour_in=3'b100, clear=0 -> 6 consecutive plot cycles at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), colour=4, then done for one cycle, busy low.
- Clipping: x0=158, y0=118, width=5, height=5 -> 4 pixels (158,118),(159,118),(158,119),(159,119), done after; no x>159 or y>119.
- Clear: clear=1, colour_in=3'b000 -> exactly 19200 plot cycles covering (0,0)..(159,119), done after; the stream ends at (159,119).
- Zero area: width=0, and separately x0=200 -> no plot; done 1 cycle after start.
- Stall and ignore: 2x2 at (0,0) with stall=1 on the 2nd pixel cycle, plus a second start pulse during DRAW -> plot pattern 1,0,1,1,1 with pixels in order, then one done; the second start has no effect.
- Async reset mid-draw: pull Resetn low during the 3rd pixel of a 4x4 draw -> all outputs 0 without waiting for a Clock edge; no done; a subsequent start draws normally from (x0,y0).
